pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of the datapath payload (ALU result, PC, store data, etc.).
REQ-002 The block SHALL have parameter CTRL_W, default 8, giving the width of the control payload (memWrt, readEn, regWrt, wbDataSel, createDump, ...).
REQ-003 The block SHALL have parameter CTRL_BUBBLE, default all-zero CTRL_W, giving the control value presented whenever the stage holds no valid instruction.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: squash all held and incoming entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream stage offers an entry.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the stage will accept an entry this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: the upstream datapath payload.
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W bits: the upstream control payload.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the stage presents a valid entry.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the entry (deasserted = stall).
REQ-013 The block SHALL have port out_data, output, DATA_W bits: the presented datapath payload.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W bits: the presented control payload.
REQ-015 The block SHALL have port occupancy, output, 2 bits: the number of held entries (0..2).

Function
REQ-016 The block SHALL hold entries in a main register (driving out_*) and a skid register, tracked by states EMPTY, ONE and TWO.
REQ-017 An entry SHALL be accepted when in_valid and in_ready are both high, and consumed when out_valid and out_ready are both high.
REQ-018 in_ready SHALL be decoded from the state register only (high in EMPTY and ONE, low in TWO), and SHALL have no combinational path from out_ready.
REQ-019 The transition EMPTY->ONE SHALL occur on accept; the accepted entry loads the main register, giving 1-cycle latency from in to out.
REQ-020 In ONE, accept with consume SHALL keep the state ONE and reload the main register; accept without consume SHALL go to TWO and load the skid register; consume without accept SHALL go to EMPTY.
REQ-021 In TWO, consume SHALL move the skid entry to the main register and go to ONE; no accept is possible in TWO.
REQ-022 The main register SHALL hold its value while out_valid is high and out_ready is low, so no entry is dropped or duplicated.
REQ-023 Entries SHALL leave in strict arrival order.
REQ-024 out_valid SHALL be 1 in ONE and TWO and 0 in EMPTY.
REQ-025 occupancy SHALL equal 0, 1 or 2 per state.
REQ-026 out_ctrl SHALL equal CTRL_BUBBLE whenever out_valid is 0.
REQ-027 out_data SHALL be don't-care whenever out_valid is 0.
REQ-028 A flush SHALL send the state to EMPTY on the next edge, regardless of in_valid or out_ready; an entry offered in the flush cycle is discarded, and flush overrides simultaneous accept or consume.
REQ-029 On the cycle after a flush, in_ready SHALL be 1 and out_valid SHALL be 0.

Reset
REQ-030 While rst is low the block SHALL immediately, without waiting for a clock edge, be in state EMPTY with out_valid=0, in_ready=1, occupancy=0, out_ctrl=CTRL_BUBBLE and out_data=0.
REQ-031 The skid register SHALL be cleared to 0 while rst is low.
REQ-032 Reset asserted mid-transfer SHALL discard all held entries, and operation SHALL resume from EMPTY on the first edge after rst rises.

Structure
REQ-033 A shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default bubble constant.
REQ-034 One sub-module pipe_en_reg SHALL be used: a WIDTH-parameterised, enable-gated register bank with async active-low clear, instantiated for the main and skid registers.
REQ-035 The state register SHALL be the only encoded FSM in the block.
REQ-036 Encoding 2'd3 SHALL be unreachable and SHALL recover to EMPTY.

Verification
REQ-037 Streaming: DATA_W=16, send 0x0001..0x0008 with in_valid=1 and out_ready=1 -> the same values appear on out_data one cycle later, one per cycle, with in_ready constantly 1.
REQ-038 Stall fill: accept 0xAAAA then 0xBBBB with out_ready=0 -> occupancy=2, in_ready=0, and out_data holds 0xAAAA; raise out_ready -> 0xAAAA then 0xBBBB are emitted in order with no loss.
REQ-039 Flush in TWO: flush=1 while offering 0xCCCC -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0 and in_ready=1; 0xCCCC is never emitted.
REQ-040 Async reset: drop rst mid-clock in state ONE -> out_valid falls before the next edge; after release, first accept 0x1234 appears one cycle later.
REQ-041 Random: random in_valid/out_ready at 50% with 10k entries against a scoreboard FIFO -> zero mismatches, zero drops, and occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: FSM state encoding,
// default bubble control value and a state-to-occupancy decode.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Wide enough for any practical control payload; instances slice it down.
  localparam int unsigned PIPE_CTRL_MAX_W = 64;
  localparam logic [PIPE_CTRL_MAX_W-1:0] PIPE_CTRL_BUBBLE = '0;

  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_en_reg.sv
// Enable-gated register bank with asynchronous active-low clear.
module pipe_en_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: state updates use <= so every flop samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline skid stage: a main register drives the outputs and a
// skid register absorbs one extra entry so in_ready comes only from state.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = PIPE_CTRL_BUBBLE[CTRL_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = DATA_W + CTRL_W;

  pipe_state_e state_q, state_d;

  logic               accept;
  logic               consume;
  logic               main_en;
  logic               skid_en;
  logic               main_from_skid;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  assign in_entry  = {in_data, in_ctrl};
  assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign occupancy = state_occupancy(state_q);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign main_d    = main_from_skid ? skid_q : in_entry;

  assign out_data  = main_q[ENTRY_W-1 -: DATA_W];
  assign out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : CTRL_BUBBLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_en_reg #(.WIDTH(ENTRY_W)) u_main_reg (
    .clk  (clk),
    .rst_n(rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  pipe_en_reg #(.WIDTH(ENTRY_W)) u_skid_reg (
    .clk  (clk),
    .rst_n(rst),
    .en_i (skid_en),
    .d_i  (in_entry),
    .q_o  (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a long
// randomized run, all compared against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int          DW     = 16;
  localparam int          CW     = 8;
  localparam logic [7:0]  BUB    = 8'h5A;
  localparam int          N_RAND = 10000;
  localparam int          BUDGET = 60000;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  entry_t model_q[$];
  int     total   = 0;
  int     bad     = 0;
  int     emitted = 0;

  pipe_skid_stage #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .CTRL_BUBBLE(BUB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[7:0] ^ 8'hC3;
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge using
  // the occupancy seen before the edge, and return at the next negedge.
  task automatic cycle(input logic f, input logic iv, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic ordy);
    bit acc;
    bit con;
    entry_t e;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    acc = iv && (model_q.size() < 2);
    con = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (con) begin
        void'(model_q.pop_front());
        emitted++;
      end
      if (acc) begin
        e.d = d;
        e.c = c;
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL reset_out_ctrl: got %0h expected %0h", out_ctrl, BUB); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      logic [DW-1:0] v;
      v = DW'(i);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      cycle(1'b0, 1'b1, v, ctrl_of(v), 1'b1);
      total++; if (out_valid !== 1'b1 || out_data !== v || out_ctrl !== ctrl_of(v))
        begin bad++; $display("FAIL stream_out[%0d]: got v=%0b d=%0h c=%0h expected v=1 d=%0h c=%0h", i, out_valid, out_data, out_ctrl, v, ctrl_of(v)); end
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_stall_fill();
    cycle(1'b0, 1'b1, 16'hAAAA, ctrl_of(16'hAAAA), 1'b0);
    cycle(1'b0, 1'b1, 16'hBBBB, ctrl_of(16'hBBBB), 1'b0);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL stall_occupancy: got %0d expected 2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
    total++; if (out_data !== 16'hAAAA) begin bad++; $display("FAIL stall_hold: got %0h expected aaaa", out_data); end
    cycle(1'b0, 1'b1, 16'hDEAD, ctrl_of(16'hDEAD), 1'b0);
    total++; if (out_data !== 16'hAAAA || occupancy !== 2'd2) begin bad++; $display("FAIL stall_full_offer: got d=%0h occ=%0d expected d=aaaa occ=2", out_data, occupancy); end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'hBBBB || out_ctrl !== ctrl_of(16'hBBBB) || occupancy !== 2'd1)
      begin bad++; $display("FAIL stall_second: got v=%0b d=%0h c=%0h occ=%0d expected v=1 d=bbbb c=%0h occ=1", out_valid, out_data, out_ctrl, occupancy, ctrl_of(16'hBBBB)); end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    total++; if (out_valid !== 1'b0 || out_ctrl !== BUB) begin bad++; $display("FAIL stall_empty: got v=%0b c=%0h expected v=0 c=%0h", out_valid, out_ctrl, BUB); end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 16'h1111, ctrl_of(16'h1111), 1'b0);
    cycle(1'b0, 1'b1, 16'h2222, ctrl_of(16'h2222), 1'b0);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_prefill: got %0d expected 2", occupancy); end
    cycle(1'b1, 1'b1, 16'hCCCC, ctrl_of(16'hCCCC), 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL flush_out_ctrl: got %0h expected %0h", out_ctrl, BUB); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost[%0d]: got out_valid=%0b d=%0h expected 0", i, out_valid, out_data); end
    end
    cycle(1'b0, 1'b1, 16'h3333, ctrl_of(16'h3333), 1'b1);
    cycle(1'b1, 1'b1, 16'h4444, ctrl_of(16'h4444), 1'b1);
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL flush_in_one: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 16'h5555, ctrl_of(16'h5555), 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h5555) begin bad++; $display("FAIL areset_pre: got v=%0b d=%0h expected v=1 d=5555", out_valid, out_data); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %0b expected 0", out_valid); end
    total++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin bad++; $display("FAIL areset_state: got rdy=%0b occ=%0d expected rdy=1 occ=0", in_ready, occupancy); end
    total++; if (out_data !== '0 || out_ctrl !== BUB) begin bad++; $display("FAIL areset_outputs: got d=%0h c=%0h expected d=0 c=%0h", out_data, out_ctrl, BUB); end
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 16'h1234, ctrl_of(16'h1234), 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_ctrl !== ctrl_of(16'h1234))
      begin bad++; $display("FAIL areset_resume: got v=%0b d=%0h c=%0h expected v=1 d=1234 c=%0h", out_valid, out_data, out_ctrl, ctrl_of(16'h1234)); end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    int sent   = 0;
    int cycles = 0;
    int start_emitted;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    start_emitted = emitted;
    while ((sent < N_RAND || model_q.size() > 0) && cycles < BUDGET && bad < 20) begin
      total++; if (out_valid !== (model_q.size() > 0)) begin bad++; $display("FAIL rand_out_valid@%0d: got %0b expected %0b", cycles, out_valid, model_q.size() > 0); end
      total++; if (in_ready !== (model_q.size() < 2)) begin bad++; $display("FAIL rand_in_ready@%0d: got %0b expected %0b", cycles, in_ready, model_q.size() < 2); end
      total++; if (occupancy !== 2'(model_q.size())) begin bad++; $display("FAIL rand_occupancy@%0d: got %0d expected %0d", cycles, occupancy, model_q.size()); end
      if (model_q.size() > 0) begin
        total++; if (out_data !== model_q[0].d || out_ctrl !== model_q[0].c)
          begin bad++; $display("FAIL rand_payload@%0d: got d=%0h c=%0h expected d=%0h c=%0h", cycles, out_data, out_ctrl, model_q[0].d, model_q[0].c); end
      end else begin
        total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL rand_bubble@%0d: got %0h expected %0h", cycles, out_ctrl, BUB); end
      end
      iv   = (sent < N_RAND) && ($urandom_range(1, 0) == 1);
      ordy = ($urandom_range(1, 0) == 1);
      d    = DW'($urandom);
      c    = CW'($urandom);
      if (iv && model_q.size() < 2) sent++;
      cycle(1'b0, iv, d, c, ordy);
      cycles++;
    end
    total++; if (cycles >= BUDGET) begin bad++; $display("FAIL rand_timeout: got %0d cycles expected fewer than %0d", cycles, BUDGET); end
    total++; if (emitted - start_emitted != N_RAND) begin bad++; $display("FAIL rand_drops: got %0d emitted expected %0d", emitted - start_emitted, N_RAND); end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_streaming();
    test_stall_fill();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
